// File: rtl/ag32gbd_bram_pkg.sv
// Shared constants, state type and address helper for the BRAM arbiter.
package ag32gbd_bram_pkg;

  localparam logic [1:0] REQ_REGW = 2'd0;
  localparam logic [1:0] REQ_BUFW = 2'd1;
  localparam logic [1:0] REQ_REGR = 2'd2;
  localparam logic [1:0] REQ_BUFR = 2'd3;

  localparam logic [9:0] BUF_A_BASE = 10'h000;
  localparam logic [9:0] BUF_B_BASE = 10'h100;
  localparam logic [9:0] REG_BASE   = 10'h200;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } arb_state_t;

  // Physical address of a byte inside one of the two image buffers.
  function automatic logic [9:0] buf_addr(input logic bank, input logic [7:0] offset);
    return (bank ? BUF_B_BASE : BUF_A_BASE) | {2'b00, offset};
  endfunction

endpackage

// File: rtl/ag32gbd_rr_arbiter4.sv
// Four-way round-robin picker: the first active request at or after ptr wins.
module ag32gbd_rr_arbiter4
  import ag32gbd_bram_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] grant,
  output logic [1:0] grant_idx
);

  logic [1:0] idx;

  // Scan from lowest to highest priority so the closest request to ptr is written last.
  always_comb begin
    grant     = 4'b0000;
    grant_idx = 2'd0;
    idx       = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        grant     = 4'b0001 << idx;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/ag32gbd_bram_arbiter.sv
// Shares one single-port 1Kx8 BRAM between four requesters and owns the
// ping-pong image buffer selection; flips happen only between transactions.
module ag32gbd_bram_arbiter
  import ag32gbd_bram_pkg::*;
#(
  parameter int         RD_LAT   = 1,
  parameter logic [9:0] REG_BASE = ag32gbd_bram_pkg::REG_BASE
) (
  input  logic        sys_clock,
  input  logic        resetn,
  input  logic [3:0]  req_valid,
  input  logic [3:0]  req_we,
  input  logic [39:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [3:0]  req_done,
  output logic        req_err,
  output logic [7:0]  rdata,
  input  logic        flip_req,
  output logic        flip_done,
  output logic        front_sel,
  output logic        bram_en,
  output logic        bram_we,
  output logic [9:0]  bram_addr,
  output logic [7:0]  bram_wdata,
  input  logic [7:0]  bram_rdata
);

  arb_state_t state, state_next;

  logic [1:0] rr_ptr;
  logic [3:0] grant_onehot;
  logic [1:0] grant_idx;
  logic [9:0] sel_addr;
  logic [9:0] grant_addr;
  logic       grant_err;
  logic       grant_start;
  logic       flip_service;
  logic       wait_last;

  logic [3:0] lat_grant;
  logic       lat_we;
  logic       lat_err;
  logic [9:0] lat_addr;
  logic [7:0] lat_wdata;
  logic [1:0] wait_cnt;
  logic       flip_pending;

  ag32gbd_rr_arbiter4 u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant_onehot),
    .grant_idx (grant_idx)
  );

  assign flip_service = (state == ST_IDLE) && flip_pending;
  assign grant_start  = (state == ST_IDLE) && !flip_pending && (|req_valid);
  assign wait_last    = (wait_cnt == 2'(RD_LAT - 1));

  // Map the winner's address: buffer requesters get a bank bit, register requesters are range-checked.
  always_comb begin
    sel_addr   = req_addr[10*grant_idx +: 10];
    grant_addr = sel_addr;
    grant_err  = 1'b0;
    case (grant_idx)
      REQ_BUFW: grant_addr = buf_addr(~front_sel, sel_addr[7:0]);
      REQ_BUFR: grant_addr = buf_addr(front_sel, sel_addr[7:0]);
      default:  grant_err  = (sel_addr < REG_BASE);
    endcase
  end

  // State register.
  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state and strobe decode; all outputs are pure functions of the registered state.
  always_comb begin
    state_next = state;
    bram_en    = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = 10'h000;
    bram_wdata = 8'h00;
    req_done   = 4'b0000;
    req_err    = 1'b0;
    flip_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        flip_done = flip_pending;
        if (grant_start) state_next = grant_err ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        bram_en    = 1'b1;
        bram_we    = lat_we;
        bram_addr  = lat_addr;
        bram_wdata = lat_wdata;
        state_next = lat_we ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_last) state_next = ST_DONE;
      end
      ST_DONE: begin
        req_done   = lat_grant;
        req_err    = lat_err;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Transaction latch, read-latency counter, read data capture and buffer flip bookkeeping.
  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      rr_ptr       <= 2'd0;
      lat_grant    <= 4'b0000;
      lat_we       <= 1'b0;
      lat_err      <= 1'b0;
      lat_addr     <= 10'h000;
      lat_wdata    <= 8'h00;
      wait_cnt     <= 2'd0;
      rdata        <= 8'h00;
      flip_pending <= 1'b0;
      front_sel    <= 1'b0;
    end else begin
      if (grant_start) begin
        rr_ptr    <= grant_idx + 2'd1;
        lat_grant <= grant_onehot;
        lat_we    <= req_we[grant_idx];
        lat_err   <= grant_err;
        lat_addr  <= grant_addr;
        lat_wdata <= req_wdata[8*grant_idx +: 8];
      end
      if (state == ST_ISSUE)     wait_cnt <= 2'd0;
      else if (state == ST_WAIT) wait_cnt <= wait_cnt + 2'd1;
      if ((state == ST_WAIT) && wait_last) rdata <= bram_rdata;
      if (flip_req)          flip_pending <= 1'b1;
      else if (flip_service) flip_pending <= 1'b0;
      if (flip_service) front_sel <= ~front_sel;
    end
  end

endmodule

// File: tb/tb_ag32gbd_bram_arbiter.sv
// Randomized bench for ag32gbd_bram_arbiter with a transaction-level reference model.
module tb_ag32gbd_bram_arbiter;

  localparam int         RD_LAT   = 3;
  localparam logic [9:0] REG_BASE = 10'h200;

  logic        sys_clock = 1'b0;
  logic        resetn;
  logic [3:0]  req_valid;
  logic [3:0]  req_we;
  logic [39:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_done;
  logic        req_err;
  logic [7:0]  rdata;
  logic        flip_req;
  logic        flip_done;
  logic        front_sel;
  logic        bram_en;
  logic        bram_we;
  logic [9:0]  bram_addr;
  logic [7:0]  bram_wdata;
  logic [7:0]  bram_rdata;

  always #5 sys_clock = ~sys_clock;

  ag32gbd_bram_arbiter #(.RD_LAT(RD_LAT), .REG_BASE(REG_BASE)) dut (
    .sys_clock  (sys_clock),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_done   (req_done),
    .req_err    (req_err),
    .rdata      (rdata),
    .flip_req   (flip_req),
    .flip_done  (flip_done),
    .front_sel  (front_sel),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .bram_rdata (bram_rdata)
  );

  function automatic logic [7:0] initByte(input int k);
    return 8'((k * 37 + 11) ^ (k >> 3));
  endfunction

  // Behavioural BRAM: data appears RD_LAT cycles after a read strobe.
  logic [7:0] mem     [1024];
  logic [7:0] rd_pipe [RD_LAT];
  assign bram_rdata = rd_pipe[RD_LAT-1];

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = initByte(k);
    for (int k = 0; k < RD_LAT; k++) rd_pipe[k] <= 8'h00;
    forever begin
      @(posedge sys_clock);
      for (int k = RD_LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
      if (bram_en) begin
        if (bram_we) mem[bram_addr] = bram_wdata;
        else         rd_pipe[0] <= mem[bram_addr];
      end
    end
  end

  // Reference model state.
  logic [7:0] ref_mem [1024];
  int         cyc;
  bit         m_idle, m_pending, m_front;
  int         m_ptr;
  logic [7:0] m_rdata;
  int         t_grant;
  bit         t_we, t_err;
  logic [9:0] t_addr;
  logic [7:0] t_wdata, t_rval;
  int         t_en_cyc, t_done_cyc;

  // Stimulus control.
  bit         rand_en, hold_all, dir_flip;
  logic [3:0] dir_raise;
  logic [9:0] dir_addr  [4];
  logic [7:0] dir_wdata [4];

  int checks, errors, flip_seen;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic resetModel();
    m_idle     = 1'b1;
    m_pending  = 1'b0;
    m_front    = 1'b0;
    m_ptr      = 0;
    m_rdata    = 8'h00;
    t_done_cyc = -1;
    t_en_cyc   = -1;
    t_err      = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_req_done"},   32'(req_done),   32'h0);
    checkOutput({tag, "_req_err"},    32'(req_err),    32'h0);
    checkOutput({tag, "_rdata"},      32'(rdata),      32'h0);
    checkOutput({tag, "_flip_done"},  32'(flip_done),  32'h0);
    checkOutput({tag, "_front_sel"},  32'(front_sel),  32'h0);
    checkOutput({tag, "_bram_en"},    32'(bram_en),    32'h0);
    checkOutput({tag, "_bram_we"},    32'(bram_we),    32'h0);
    checkOutput({tag, "_bram_addr"},  32'(bram_addr),  32'h0);
    checkOutput({tag, "_bram_wdata"}, 32'(bram_wdata), 32'h0);
  endtask

  task automatic newParams(input int i);
    logic [9:0] a;
    if ((i == 0 || i == 2) && $urandom_range(0, 4) != 0) a = 10'($urandom_range(REG_BASE, 1023));
    else a = 10'($urandom_range(0, 1023));
    req_addr[10*i +: 10] = a;
    req_wdata[8*i +: 8]  = 8'($urandom);
  endtask

  task automatic queueReq(input int i, input logic [9:0] a, input logic [7:0] d);
    dir_raise[i] = 1'b1;
    dir_addr[i]  = a;
    dir_wdata[i] = d;
  endtask

  task automatic compareOutputs();
    bit done_now, en_now;
    done_now = !m_idle && (cyc == t_done_cyc);
    en_now   = !m_idle && !t_err && (cyc == t_en_cyc);
    checkOutput("req_done",  32'(req_done),  done_now ? (32'h1 << t_grant) : 32'h0);
    checkOutput("req_err",   32'(req_err),   32'(done_now && t_err));
    checkOutput("flip_done", 32'(flip_done), 32'(m_idle && m_pending));
    checkOutput("front_sel", 32'(front_sel), 32'(m_front));
    checkOutput("rdata",     32'(rdata),     32'(m_rdata));
    checkOutput("bram_en",   32'(bram_en),   32'(en_now));
    if (en_now) begin
      checkOutput("bram_we",   32'(bram_we),   32'(t_we));
      checkOutput("bram_addr", 32'(bram_addr), 32'(t_addr));
      if (t_we) checkOutput("bram_wdata", 32'(bram_wdata), 32'(t_wdata));
    end
  endtask

  // Drive requester and flip inputs for the current cycle.
  task automatic applyStimulus(input bit done_now);
    if (done_now) begin
      if (hold_all || (rand_en && $urandom_range(0, 3) == 0)) newParams(t_grant);
      else req_valid[t_grant] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (!req_valid[i]) begin
        if (dir_raise[i]) begin
          req_valid[i]         = 1'b1;
          req_addr[10*i +: 10] = dir_addr[i];
          req_wdata[8*i +: 8]  = dir_wdata[i];
          dir_raise[i]         = 1'b0;
        end else if (hold_all || (rand_en && $urandom_range(0, 5) == 0)) begin
          newParams(i);
          req_valid[i] = 1'b1;
        end
      end
    end
    flip_req = dir_flip || (rand_en && $urandom_range(0, 15) == 0);
    dir_flip = 1'b0;
  endtask

  task automatic grantModel();
    int         g, idx;
    logic [9:0] raw;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      idx = (m_ptr + k) % 4;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    raw     = req_addr[10*g +: 10];
    t_grant = g;
    t_we    = (g == 0 || g == 1);
    case (g)
      1:       t_addr = {1'b0, ~m_front, raw[7:0]};
      3:       t_addr = {1'b0, m_front, raw[7:0]};
      default: t_addr = raw;
    endcase
    t_err      = (g == 0 || g == 2) && (raw < REG_BASE);
    t_wdata    = req_wdata[8*g +: 8];
    t_en_cyc   = cyc + 1;
    t_done_cyc = cyc + (t_err ? 1 : (t_we ? 2 : 2 + RD_LAT));
    if (!t_err) begin
      if (t_we) ref_mem[t_addr] = t_wdata;
      else      t_rval = ref_mem[t_addr];
    end
    m_ptr  = (g + 1) % 4;
    m_idle = 1'b0;
  endtask

  task automatic advanceModel();
    if (m_idle && m_pending) begin
      m_front   = ~m_front;
      m_pending = flip_req;
    end else begin
      if (m_idle && (|req_valid)) grantModel();
      else if (!m_idle && cyc == t_done_cyc) m_idle = 1'b1;
      if (flip_req) m_pending = 1'b1;
    end
    cyc++;
    if (!m_idle && cyc == t_done_cyc && !t_we && !t_err) m_rdata = t_rval;
  endtask

  task automatic runCycle();
    bit done_now;
    done_now = !m_idle && (cyc == t_done_cyc);
    compareOutputs();
    if (flip_done === 1'b1) flip_seen++;
    applyStimulus(done_now);
    advanceModel();
  endtask

  function automatic bit isQuiet();
    return m_idle && !m_pending && (req_valid == 4'b0000) && (dir_raise == 4'b0000) && !dir_flip;
  endfunction

  task automatic runUntilQuiet(input int limit, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge sys_clock);
      runCycle();
      n++;
    end while (!isQuiet() && n < limit);
    if (!isQuiet()) checkOutput({tag, "_timeout"}, 32'h1, 32'h0);
  endtask

  function automatic bit inWait();
    return !m_idle && !t_err && !t_we && (cyc > t_en_cyc) && (cyc < t_done_cyc);
  endfunction

  initial begin
    int f0, n, diffs;
    checks = 0; errors = 0; flip_seen = 0; cyc = 0;
    rand_en = 1'b0; hold_all = 1'b0; dir_flip = 1'b0; dir_raise = 4'b0000;
    for (int k = 0; k < 4; k++) begin dir_addr[k] = 10'h0; dir_wdata[k] = 8'h0; end
    for (int k = 0; k < 1024; k++) ref_mem[k] = initByte(k);
    resetn = 1'b0; req_valid = 4'b0000; req_we = 4'b0011;
    req_addr = 40'h0; req_wdata = 32'h0; flip_req = 1'b0;
    resetModel();
    repeat (3) @(negedge sys_clock);
    checkReset("por");
    resetn = 1'b1;
    runCycle();

    $display("[TB] buffer write, flip, readback");
    queueReq(1, 10'h305, 8'hA5);
    runUntilQuiet(40, "bufw");
    dir_flip = 1'b1;
    runUntilQuiet(40, "flip1");
    queueReq(3, 10'h205, 8'h00);
    runUntilQuiet(40, "bufr");
    checkOutput("readback_buf", 32'(rdata), 32'hA5);

    $display("[TB] rejected register write, register write/read");
    queueReq(0, 10'h0FF, 8'h77);
    runUntilQuiet(40, "reject");
    queueReq(0, 10'h210, 8'h3C);
    runUntilQuiet(40, "regw");
    queueReq(2, 10'h210, 8'h00);
    runUntilQuiet(40, "regr");
    checkOutput("reg_read", 32'(rdata), 32'h3C);

    $display("[TB] flips coalesced during a read");
    f0 = flip_seen;
    queueReq(3, 10'h010, 8'h00);
    @(negedge sys_clock); runCycle();
    for (int k = 0; k < 3; k++) begin
      dir_flip = 1'b1;
      @(negedge sys_clock); runCycle();
    end
    runUntilQuiet(60, "coalesce");
    checkOutput("flip_coalesce", 32'(flip_seen - f0), 32'h1);

    $display("[TB] all requesters continuously valid");
    hold_all = 1'b1;
    repeat (80) begin @(negedge sys_clock); runCycle(); end
    hold_all = 1'b0;
    runUntilQuiet(100, "hold");

    $display("[TB] random traffic");
    rand_en = 1'b1;
    repeat (1500) begin @(negedge sys_clock); runCycle(); end

    $display("[TB] reset during read wait");
    n = 0;
    while (!inWait() && n < 2000) begin @(negedge sys_clock); runCycle(); n++; end
    checkOutput("reach_wait", 32'(inWait()), 32'h1);
    @(posedge sys_clock);
    #2;
    resetn = 1'b0;
    #1;
    checkReset("mid_wait");
    rand_en = 1'b0; dir_raise = 4'b0000; dir_flip = 1'b0;
    req_valid = 4'b0000; flip_req = 1'b0;
    repeat (RD_LAT + 3) begin
      @(negedge sys_clock);
      checkOutput("no_done_in_reset", 32'(req_done), 32'h0);
    end
    resetn = 1'b1;
    resetModel();
    runCycle();
    queueReq(2, 10'h210, 8'h00);
    runUntilQuiet(40, "post_reset");
    checkOutput("post_reset_read", 32'(rdata), 32'(ref_mem[10'h210]));

    rand_en = 1'b1;
    repeat (800) begin @(negedge sys_clock); runCycle(); end
    rand_en = 1'b0;
    runUntilQuiet(200, "drain");

    diffs = 0;
    for (int k = 0; k < 1024; k++) if (mem[k] !== ref_mem[k]) diffs++;
    checkOutput("mem_image", 32'(diffs), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ag32gbd_bram_arbiter.md
Name: ag32gbd_bram_arbiter

Overview:
- Shares one single-port 1K x 8 block RAM among four requesters:
  - 0 = register write (cart reg shadow)
  - 1 = image buffer write (camera pipeline)
  - 2 = register read (sensor sequencer)
  - 3 = image buffer read (cart RAM writeback)
- Owns ping-pong image buffer selection.
- Translates buffer offsets to physical addresses and executes buffer flips only between transactions.
- Sits between the camera/register/RAM-write blocks and the BRAM macro.

Parameters:
- RD_LAT, 1, BRAM read latency in cycles from bram_en to valid bram_rdata (1..3).
- REG_BASE, 10'h200, lowest legal address for requesters 0 and 2.

Ports:
- sys_clock  in  1  system clock, all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  4  per-requester request, held until matching req_done.
- req_we  in  4  1 = write, 0 = read; sampled with req_valid.
- req_addr  in  40  4 x 10-bit packed, requester n at [10n+9:10n]. For requesters 1 and 3, only [7:0] is used, as a buffer offset.
- req_wdata  in  32  4 x 8-bit packed write data.
- req_done  out  4  one-cycle completion pulse per requester.
- req_err  out  1  pulses with req_done when the access was rejected.
- rdata  out  8  last read result; valid from the req_done cycle, held until the next read completes.
- flip_req  in  1  pulse: swap front/back image buffers.
- flip_done  out  1  one-cycle pulse when the swap takes effect.
- front_sel  out  1  current read-side buffer (0 = 0x000-0x0FF, 1 = 0x100-0x1FF).
- bram_en, bram_we  out  1 each  BRAM strobes.
- bram_addr  out  10  BRAM address.
- bram_wdata  out  8  BRAM write data.
- bram_rdata  in  8  BRAM read data.

Behaviour:
- Reset values: all outputs 0. front_sel = 0, rr pointer = 0, flip_pending = 0, state IDLE.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If flip_pending: toggle front_sel, pulse flip_done, clear flip_pending, stay IDLE. No grant in this cycle.
  - Else if any req_valid: grant round-robin starting at rr pointer, set rr = grant+1 mod 4, latch we/addr/wdata, go to ISSUE.
- ISSUE (1 cycle): drive bram_en = 1, bram_we = latched we, bram_addr, bram_wdata.
  - Write: go to DONE.
  - Read: go to WAIT.
- WAIT: count RD_LAT cycles, capture bram_rdata into rdata on the last one, go to DONE.
- DONE: pulse req_done[grant], go to IDLE.
- Latency (request seen in IDLE at cycle T):
  - Write: bram_en at T+1, req_done at T+2.
  - Read: bram_en at T+1, rdata updated and req_done at T+2+RD_LAT.
- Address mapping:
  - Requester 1 (buffer write): {1'b0, ~front_sel, offset}, i.e. back buffer.
  - Requester 3 (buffer read): {1'b0, front_sel, offset}, i.e. front buffer.
  - Requesters 0 and 2: raw address.
- Bank capture: the bank bit is captured at grant. A later flip never retargets an in-flight access.
- Rejected access: requester 0 or 2 with addr < REG_BASE. No bram_en; go IDLE -> DONE directly. req_done and req_err pulse at T+1. rdata is unchanged.
- flip_req:
  - Sets flip_pending in any state; it is serviced at the next IDLE cycle.
  - Multiple flip_req pulses before service coalesce into one flip and one flip_done.
- Requester holding req_valid after req_done: treated as a new transaction and re-arbitrated fairly behind the others.
- Request dropped before grant: ignored. Dropping after grant is illegal; the transaction completes anyway.
- Simultaneous flip_req and request in IDLE with flip_pending = 0: the request is granted first. The flip follows the transaction.
- Asynchronous reset mid-transaction: transaction abandoned, no req_done, state and outputs return to reset values.
- Starvation bound: every pending requester is granted within 4 transactions plus at most 4 flip cycles.

Decomposition:
- Package ag32gbd_bram_pkg:
  - requester index constants (REQ_REGW = 0, REQ_BUFW = 1, REQ_REGR = 2, REQ_BUFR = 3)
  - BUF_A_BASE = 10'h000, BUF_B_BASE = 10'h100, REG_BASE = 10'h200
  - state enum
- One natural sub-module: ag32gbd_rr_arbiter4. Inputs: 4-bit request vector and pointer. Outputs: one-hot grant and encoded index. Purely combinational.

Test Plan:
- Single write, requester 1, offset 0x05, data 0xA5, front_sel = 0 -> bram_we at T+1 with addr 0x105; req_done[1] at T+2; readback via requester 3 after one flip returns 0xA5.
- All four requesters valid continuously from reset -> grant order 0, 1, 2, 3, 0, ...; no requester gets two grants while another waits.
- Requester 2 read of 0x210 holding 0x3C, RD_LAT = 1 and RD_LAT = 3 -> rdata = 0x3C with req_done[2] at T+3 and T+5 respectively.
- flip_req pulsed three times during a pending read -> exactly one flip_done, in the first IDLE after req_done; front_sel toggles once; the read used the pre-flip bank.
- Requester 0 write to 0x0FF -> no bram_en; req_done[0] and req_err at T+1; BRAM contents unchanged.
- resetn asserted during WAIT -> no req_done; all outputs 0, front_sel = 0; a post-reset read completes normally.
